// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
// Segment vectors are ordered g..a and are active-low.
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } scanState_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_lut.sv
// Combinational hex nibble to active-low 7-segment (g..a) decoder.
module seg7_lut
  import display_pkg::*;
(
  input  logic [3:0] iNibble,
  output logic [6:0] oSeg
);

  always_comb begin
    oSeg = SEG_OFF;
    case (iNibble)
      4'h0: oSeg = SEG_0;
      4'h1: oSeg = SEG_1;
      4'h2: oSeg = SEG_2;
      4'h3: oSeg = SEG_3;
      4'h4: oSeg = SEG_4;
      4'h5: oSeg = SEG_5;
      4'h6: oSeg = SEG_6;
      4'h7: oSeg = SEG_7;
      4'h8: oSeg = SEG_8;
      4'h9: oSeg = SEG_9;
      4'hA: oSeg = SEG_A;
      4'hB: oSeg = SEG_B;
      4'hC: oSeg = SEG_C;
      4'hD: oSeg = SEG_D;
      4'hE: oSeg = SEG_E;
      4'hF: oSeg = SEG_F;
      default: oSeg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode display scanner with dead time and frame-aligned double buffering.
// Optional SCAN_LEADING_ZERO_BLANK_EN darkens leading zero digits at commit time.
//
// state | meaning
// DEAD  | all anodes off for one cycle at a digit switch
// SHOW  | anode idx on, segments driven from the committed buffer
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 50000
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic [4*NUM_DIGITS-1:0] iData,
  input  logic [NUM_DIGITS-1:0]   iBlank,
  input  logic                    iLoad,
  output logic [6:0]              oSeg,
  output logic [NUM_DIGITS-1:0]   oAn,
  output logic                    oFrame,
  output logic                    oPending
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  scanState_t state, stateNext;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, idxNext;
  logic tick, wrap;

  logic [NUM_DIGITS-1:0][3:0] pendData, disp;
  logic [NUM_DIGITS-1:0]      pendBlank, blank, lzMask;
  logic [6:0]                 lutSeg, segNext;
  logic [NUM_DIGITS-1:0]      anNext;

  assign tick = (state == SHOW) && (cnt == LAST_CNT);
  assign wrap = tick && (idx == LAST_IDX);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state <= DEAD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
      cnt   <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    case (state)
      DEAD: stateNext = SHOW;
      SHOW: begin
        if (tick) begin
          stateNext = DEAD;
          idxNext   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
      end
      default: stateNext = DEAD;
    endcase
  end

  // Decode from the next index so the registered outputs line up with the state register.
  seg7_lut uLut (
    .iNibble(disp[idxNext]),
    .oSeg   (lutSeg)
  );

  always_comb begin
    segNext = SEG_OFF;
    anNext  = '1;
    if (stateNext == SHOW) begin
      anNext[idxNext] = 1'b0;
      if (!blank[idxNext]) segNext = lutSeg;
    end
  end

`ifdef SCAN_LEADING_ZERO_BLANK_EN
  function automatic logic [NUM_DIGITS-1:0] leadZeroMask(
    input logic [NUM_DIGITS-1:0][3:0] nib,
    input logic [NUM_DIGITS-1:0]      bl
  );
    logic [NUM_DIGITS-1:0] mask;
    logic upperDark;
    mask      = '0;
    upperDark = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (upperDark && (nib[k] == 4'h0)) mask[k] = 1'b1;
      upperDark = upperDark && ((nib[k] == 4'h0) || bl[k]);
    end
    return mask;
  endfunction

  assign lzMask = leadZeroMask(pendData, pendBlank);
`else
  assign lzMask = '0;
`endif

  always_ff @(posedge iClk) begin
    if (iReset) begin
      pendData  <= '0;
      pendBlank <= '1;
      oPending  <= 1'b0;
      disp      <= '0;
      blank     <= '1;
      oSeg      <= SEG_OFF;
      oAn       <= '1;
      oFrame    <= 1'b0;
    end else begin
      oSeg   <= segNext;
      oAn    <= anNext;
      oFrame <= wrap;
      if (wrap && oPending) begin
        disp  <= pendData;
        blank <= pendBlank | lzMask;
      end
      // A load on the commit tick refills pending after the old contents commit.
      if (iLoad) begin
        pendData  <= iData;
        pendBlank <= iBlank;
        oPending  <= 1'b1;
      end else if (wrap) begin
        oPending  <= 1'b0;
      end
    end
  end

endmodule
